vending_payer: RTL and testbench
================================

// Module: vending_payer
// PURPOSE
//  Customer-side driver for the vending machine coin interface: turns a buy
//  request into a paced sequence of one-cycle pOne/pHalf coin pulses and
//  consumes the machine's PCola/PMoney replies. It keeps a small coin wallet,
//  checks funds before paying and reports completion, change and timeouts.
//  It sits between test/UI logic and the vending machine, on the same clock.
// PARAMETERS
//  PRICE_H   5   cola price in half-yuan units (5 = 2.5 yuan)
//  CNT_W     4   width of wallet and statistics counters
//  GAP_CYC   2   idle cycles between coin pulses (>=1)
//  TIMEOUT   8   cycles to wait for PCola after last coin (>=1)
// PORTS
//  sys_clk     in   1      system clock, rising edge
//  sys_rst_n   in   1      asynchronous active-low reset
//  buy_req     in   1      one-cycle request to buy one cola
//  refill      in   1      one-cycle wallet refill strobe
//  refill_one  in   CNT_W  1-yuan coins added on refill
//  refill_half in   CNT_W  0.5-yuan coins added on refill
//  PCola       in   1      cola dispensed (from vending machine)
//  PMoney      in   1      0.5-yuan change returned (from vending machine)
//  pOne        out  1      one-cycle 1-yuan insertion pulse
//  pHalf       out  1      one-cycle 0.5-yuan insertion pulse
//  busy        out  1      high from accepted buy_req until done/err pulse
//  done        out  1      one-cycle pulse: cola received
//  err_funds   out  1      one-cycle pulse: buy rejected, wallet short
//  err_tmo     out  1      one-cycle pulse: no PCola within TIMEOUT
//  one_cnt     out  CNT_W  1-yuan coins held
//  half_cnt    out  CNT_W  0.5-yuan coins held
//  cola_cnt    out  CNT_W  colas received, wraps
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; wallet counts 0; outputs registered.
//  - FSM: IDLE -> INSERT -> GAP -> (INSERT | WAIT) -> IDLE.
//  - IDLE: buy_req with 2*one_cnt+half_cnt >= PRICE_H (computed CNT_W+2 wide):
//    load due=PRICE_H, busy=1, go INSERT next cycle. Insufficient: err_funds
//    pulse next cycle, stay IDLE, wallet untouched.
//  - INSERT (1 cycle): coin choice: due>=2 & one_cnt>0 -> pOne, due-=2;
//    else half_cnt>0 -> pHalf, due-=1; else pOne, due=0 (overpay by 0.5).
//    Chosen wallet count decrements same cycle. pOne/pHalf never both high.
//  - GAP: GAP_CYC cycles with coin outputs low; then INSERT if due>0, else WAIT.
//  - WAIT: count up to TIMEOUT cycles. PCola=1 -> done pulse next cycle,
//    cola_cnt+1, busy=0, IDLE. Counter expiry -> err_tmo pulse, busy=0, IDLE.
//  - PMoney=1 in any state adds one 0.5 coin to half_cnt (saturating at max).
//  - buy_req while busy ignored (not queued). PCola outside WAIT ignored.
//  - refill: accepted only in IDLE and not same cycle as buy_req (buy wins,
//    refill dropped); adds saturating at 2^CNT_W-1.
//  - Reset mid-operation: pulses stop immediately; coins already sent are lost.
// TESTING
//  1 refill one=3,half=0; buy -> pOne,pOne,pOne spaced GAP_CYC; with machine
//    model PCola+PMoney -> done, one_cnt=0, half_cnt=1, cola_cnt=1.
//  2 wallet one=2,half=1; buy -> pOne,pOne,pHalf; PCola, no PMoney -> done,
//    wallet empty.
//  3 wallet one=0,half=4; buy -> err_funds 1 cycle later, no coin pulses.
//  4 buy with PCola held low -> err_tmo exactly TIMEOUT cycles after WAIT entry.
//  5 buy_req and refill together, and buy_req while busy -> both ignored, one
//    purchase only.
//  6 sys_rst_n low during GAP -> all outputs 0 async, FSM IDLE, counts 0.

Source files
------------

// File: rtl/vending_payer.sv
// Customer-side coin driver for the vending machine: pays for one cola with paced
// pOne/pHalf pulses from a small wallet and reports done, change and timeouts.
module vending_payer #(
    parameter int unsigned PRICE_H = 5,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             buy_req,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_one,
    input  logic [CNT_W-1:0] refill_half,
    input  logic             PCola,
    input  logic             PMoney,
    output logic             pOne,
    output logic             pHalf,
    output logic             busy,
    output logic             done,
    output logic             err_funds,
    output logic             err_tmo,
    output logic [CNT_W-1:0] one_cnt,
    output logic [CNT_W-1:0] half_cnt,
    output logic [CNT_W-1:0] cola_cnt
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INSERT = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [SUM_W-1:0] due, due_nxt, due_in, funds;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             pone_nxt, phalf_nxt, busy_nxt, done_nxt, errf_nxt, errt_nxt;
    logic [CNT_W-1:0] one_nxt, half_nxt, cola_nxt;
    logic             take_coin, refill_ok;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign funds = (SUM_W'(one_cnt) << 1) + SUM_W'(half_cnt);

    // Next-state, coin selection and wallet bookkeeping.
    always_comb begin
        state_nxt = state;
        due_nxt   = due;
        due_in    = due;
        gap_nxt   = gap_cnt;
        tmo_nxt   = tmo_cnt;
        pone_nxt  = 1'b0;
        phalf_nxt = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        errf_nxt  = 1'b0;
        errt_nxt  = 1'b0;
        one_nxt   = one_cnt;
        half_nxt  = half_cnt;
        cola_nxt  = cola_cnt;
        take_coin = 1'b0;
        refill_ok = 1'b0;

        case (state)
            S_IDLE: begin
                if (buy_req) begin
                    if (funds >= SUM_W'(PRICE_H)) begin
                        busy_nxt  = 1'b1;
                        take_coin = 1'b1;
                        due_in    = SUM_W'(PRICE_H);
                        state_nxt = S_INSERT;
                    end else begin
                        errf_nxt = 1'b1;
                    end
                end else if (refill) begin
                    refill_ok = 1'b1;
                end
            end
            S_INSERT: begin
                gap_nxt   = '0;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    if (due != '0) begin
                        take_coin = 1'b1;
                        state_nxt = S_INSERT;
                    end else begin
                        tmo_nxt   = '0;
                        state_nxt = S_WAIT;
                    end
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                if (PCola) begin
                    done_nxt  = 1'b1;
                    cola_nxt  = cola_cnt + CNT_W'(1);
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    errt_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
        endcase

        // Coin pulse is registered so it is high exactly during INSERT.
        if (take_coin) begin
            if (due_in >= SUM_W'(2) && one_cnt != '0) begin
                pone_nxt = 1'b1;
                one_nxt  = one_cnt - CNT_W'(1);
                due_nxt  = due_in - SUM_W'(2);
            end else if (half_cnt != '0) begin
                phalf_nxt = 1'b1;
                half_nxt  = half_cnt - CNT_W'(1);
                due_nxt   = due_in - SUM_W'(1);
            end else begin
                pone_nxt = 1'b1;
                if (one_cnt != '0) begin
                    one_nxt = one_cnt - CNT_W'(1);
                end
                due_nxt = '0;
            end
        end

        if (PMoney) begin
            half_nxt = sat_add(half_nxt, CNT_W'(1));
        end
        if (refill_ok) begin
            one_nxt  = sat_add(one_nxt, refill_one);
            half_nxt = sat_add(half_nxt, refill_half);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            due       <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            pOne      <= 1'b0;
            pHalf     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_funds <= 1'b0;
            err_tmo   <= 1'b0;
            one_cnt   <= '0;
            half_cnt  <= '0;
            cola_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            due       <= due_nxt;
            gap_cnt   <= gap_nxt;
            tmo_cnt   <= tmo_nxt;
            pOne      <= pone_nxt;
            pHalf     <= phalf_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err_funds <= errf_nxt;
            err_tmo   <= errt_nxt;
            one_cnt   <= one_nxt;
            half_cnt  <= half_nxt;
            cola_cnt  <= cola_nxt;
        end
    end

endmodule

// File: tb/tb_vending_payer.sv
// Scoreboard bench for vending_payer: expected output snapshots are queued with the
// cycle they must appear on; a negedge monitor pops and compares them.
module tb_vending_payer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       buy_req, refill, PCola, PMoney;
    logic [3:0] refill_one, refill_half;
    logic       pOne, pHalf, busy, done, err_funds, err_tmo;
    logic [3:0] one_cnt, half_cnt, cola_cnt;

    vending_payer #(.PRICE_H(5), .CNT_W(4), .GAP_CYC(2), .TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .buy_req(buy_req), .refill(refill),
        .refill_one(refill_one), .refill_half(refill_half), .PCola(PCola), .PMoney(PMoney),
        .pOne(pOne), .pHalf(pHalf), .busy(busy), .done(done), .err_funds(err_funds),
        .err_tmo(err_tmo), .one_cnt(one_cnt), .half_cnt(half_cnt), .cola_cnt(cola_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // {pOne, pHalf, done, err_funds, err_tmo, busy}
    localparam logic [5:0] P_IDLE = 6'b000000;
    localparam logic [5:0] P_BUSY = 6'b000001;
    localparam logic [5:0] P_ONE  = 6'b100001;
    localparam logic [5:0] P_HALF = 6'b010001;
    localparam logic [5:0] P_DONE = 6'b001000;
    localparam logic [5:0] P_EF   = 6'b000100;
    localparam logic [5:0] P_TMO  = 6'b000010;

    typedef struct {
        int          cyc;
        logic [17:0] vec;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string n, input int c, input logic [5:0] p,
                        input logic [3:0] o, input logic [3:0] h, input logic [3:0] k);
        exp_t e;
        e.cyc  = c;
        e.vec  = {p, o, h, k};
        e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    task automatic do_refill(input logic [3:0] o, input logic [3:0] h,
                             input logic [3:0] eo, input logic [3:0] eh, input logic [3:0] ek);
        push("refill", cyc + 1, P_IDLE, eo, eh, ek);
        refill = 1'b1; refill_one = o; refill_half = h;
        step();
        refill = 1'b0; refill_one = '0; refill_half = '0;
    endtask

    // Monitor: compares every scheduled snapshot and flags any unscheduled pulse.
    always @(negedge sys_clk) begin
        logic [17:0] act;
        exp_t        e;
        act = {pOne, pHalf, done, err_funds, err_tmo, busy, one_cnt, half_cnt, cola_cnt};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expected at cycle %0d, not seen (now %0d)", e.name, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (act !== e.vec) begin
                bad++;
                $display("FAIL %s @%0d: got %b_%h_%h_%h want %b_%h_%h_%h", e.name, cyc,
                         act[17:12], act[11:8], act[7:4], act[3:0],
                         e.vec[17:12], e.vec[11:8], e.vec[7:4], e.vec[3:0]);
            end
        end else if (|act[17:13]) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse @%0d: got %b want 00000", cyc, act[17:13]);
        end
    end

    initial begin
        int b;
        sys_rst_n = 1'b0;
        buy_req = 1'b0; refill = 1'b0; PCola = 1'b0; PMoney = 1'b0;
        refill_one = '0; refill_half = '0;

        push("reset_state", 2, P_IDLE, 4'd0, 4'd0, 4'd0);
        wait_cyc(3);
        sys_rst_n = 1'b1;
        step();

        // 1: three 1-yuan coins, machine returns change
        do_refill(4'd3, 4'd0, 4'd3, 4'd0, 4'd0);
        b = cyc;
        push("t1_coin1", b + 1,  P_ONE,  4'd2, 4'd0, 4'd0);
        push("t1_coin2", b + 4,  P_ONE,  4'd1, 4'd0, 4'd0);
        push("t1_coin3", b + 7,  P_ONE,  4'd0, 4'd0, 4'd0);
        push("t1_gap",   b + 9,  P_BUSY, 4'd0, 4'd0, 4'd0);
        push("t1_done",  b + 12, P_DONE, 4'd0, 4'd1, 4'd1);
        push("t1_idle",  b + 13, P_IDLE, 4'd0, 4'd1, 4'd1);
        buy_req = 1'b1; step(); buy_req = 1'b0;
        wait_cyc(b + 11);
        PCola = 1'b1; PMoney = 1'b1; step(); PCola = 1'b0; PMoney = 1'b0;
        wait_cyc(b + 14);

        // 2: two ones and a half, exact payment
        do_refill(4'd2, 4'd0, 4'd2, 4'd1, 4'd1);
        b = cyc;
        push("t2_coin1", b + 1,  P_ONE,  4'd1, 4'd1, 4'd1);
        push("t2_coin2", b + 4,  P_ONE,  4'd0, 4'd1, 4'd1);
        push("t2_coin3", b + 7,  P_HALF, 4'd0, 4'd0, 4'd1);
        push("t2_done",  b + 12, P_DONE, 4'd0, 4'd0, 4'd2);
        buy_req = 1'b1; step(); buy_req = 1'b0;
        wait_cyc(b + 11);
        PCola = 1'b1; step(); PCola = 1'b0;
        wait_cyc(b + 14);

        // 3: four halves is short of 2.5 yuan
        do_refill(4'd0, 4'd4, 4'd0, 4'd4, 4'd2);
        b = cyc;
        push("t3_err_funds", b + 1, P_EF,   4'd0, 4'd4, 4'd2);
        push("t3_idle",      b + 2, P_IDLE, 4'd0, 4'd4, 4'd2);
        buy_req = 1'b1; step(); buy_req = 1'b0;
        wait_cyc(b + 4);

        // 4: no PCola, timeout TIMEOUT cycles after WAIT entry
        do_refill(4'd3, 4'd0, 4'd3, 4'd4, 4'd2);
        b = cyc;
        push("t4_coin1",   b + 1,  P_ONE,  4'd2, 4'd4, 4'd2);
        push("t4_coin2",   b + 4,  P_ONE,  4'd1, 4'd4, 4'd2);
        push("t4_coin3",   b + 7,  P_HALF, 4'd1, 4'd3, 4'd2);
        push("t4_wait",    b + 17, P_BUSY, 4'd1, 4'd3, 4'd2);
        push("t4_err_tmo", b + 18, P_TMO,  4'd1, 4'd3, 4'd2);
        buy_req = 1'b1; step(); buy_req = 1'b0;
        wait_cyc(b + 20);

        // 5: refill with buy is dropped; buy and refill while busy ignored
        b = cyc;
        push("t5_coin1", b + 1,  P_ONE,  4'd0, 4'd3, 4'd2);
        push("t5_coin2", b + 4,  P_HALF, 4'd0, 4'd2, 4'd2);
        push("t5_coin3", b + 7,  P_HALF, 4'd0, 4'd1, 4'd2);
        push("t5_coin4", b + 10, P_HALF, 4'd0, 4'd0, 4'd2);
        push("t5_done",  b + 15, P_DONE, 4'd0, 4'd0, 4'd3);
        push("t5_idle",  b + 17, P_IDLE, 4'd0, 4'd0, 4'd3);
        buy_req = 1'b1; refill = 1'b1; refill_one = 4'd5; refill_half = 4'd5;
        step();
        buy_req = 1'b0; refill = 1'b0; refill_one = '0; refill_half = '0;
        wait_cyc(b + 2);
        buy_req = 1'b1; step(); buy_req = 1'b0;
        wait_cyc(b + 5);
        refill = 1'b1; refill_one = 4'd7; step(); refill = 1'b0; refill_one = '0;
        wait_cyc(b + 14);
        PCola = 1'b1; step(); PCola = 1'b0;
        wait_cyc(b + 19);

        // 6: reset asserted mid-cycle during GAP clears everything at once
        do_refill(4'd3, 4'd0, 4'd3, 4'd0, 4'd3);
        b = cyc;
        push("t6_coin1",     b + 1, P_ONE,  4'd2, 4'd0, 4'd3);
        push("t6_rst_async", b + 2, P_IDLE, 4'd0, 4'd0, 4'd0);
        push("t6_rst_hold",  b + 3, P_IDLE, 4'd0, 4'd0, 4'd0);
        buy_req = 1'b1; step(); buy_req = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        wait_cyc(b + 4);
        sys_rst_n = 1'b1;
        step();
        b = cyc;
        push("t6_idle_after_rst", b + 1, P_EF, 4'd0, 4'd0, 4'd0);
        buy_req = 1'b1; step(); buy_req = 1'b0;

        push("final_idle", cyc + 2, P_IDLE, 4'd0, 4'd0, 4'd0);
        wait_cyc(cyc + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
